// File: rtl/gate_arbiter_if.sv
// Request/result bundle between the shared gate unit and its clients.
// The master side is the client population; the slave side is gate_arbiter.
interface gate_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req;
   logic [2*NREQ-1:0] op;
   logic [W*NREQ-1:0] a;
   logic [W*NREQ-1:0] b;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic              res_valid;
   logic              res_ready;
   logic [IDW-1:0]    res_id;
   logic [W-1:0]      res_data;

   modport master (
      output req, op, a, b, res_ready,
      input  gnt, busy, res_valid, res_id, res_data
   );

   modport slave (
      input  req, op, a, b, res_ready,
      output gnt, busy, res_valid, res_id, res_data
   );
endinterface

// File: rtl/gate_arbiter.sv
// Round-robin shared AND/OR/XOR/NAND unit: grant, latch operands, compute,
// then hold the tagged result until the consumer takes it.
module gate_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   gate_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   op_e             op_q, op_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [IDW-1:0]  id_q, id_d;
   logic            res_valid_q, res_valid_d;
   logic [IDW-1:0]  res_id_q, res_id_d;
   logic [W-1:0]    res_data_q, res_data_d;

   logic [IDW-1:0]  winner;
   logic [IDW-1:0]  idx;
   logic            found;

   function automatic logic [W-1:0] gate_eval(op_e f, logic [W-1:0] x, logic [W-1:0] y);
      logic [W-1:0] r;
      unique case (f)
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_XOR:  r = x ^ y;
         OP_NAND: r = ~(x & y);
         default: r = '0;
      endcase
      return r;
   endfunction

   // Rotating priority: the IDW-bit add wraps the index at NREQ for free.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr_q + IDW'(k);
         if (!found && bus.req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path can infer a latch.
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = '0;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      res_valid_d = res_valid_q;
      res_id_d    = res_id_q;
      res_data_d  = res_data_q;

      unique case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d   = NREQ'(1) << winner;
               op_d    = op_e'(bus.op[2*winner +: 2]);
               a_d     = bus.a[W*winner +: W];
               b_d     = bus.b[W*winner +: W];
               id_d    = winner;
               ptr_d   = winner + IDW'(1);
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_data_d  = gate_eval(op_q, a_q, b_q);
            res_id_d    = id_q;
            res_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         // NOTE: the latched operands are cleared too, so a reset leaves no stale request behind.
         op_q        <= OP_AND;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_data_q  <= res_data_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.res_valid = res_valid_q;
   assign bus.res_id    = res_id_q;
   assign bus.res_data  = res_data_q;

   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

   a_res_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (res_valid_q && !bus.res_ready) |=>
         (res_valid_q && $stable(res_id_q) && $stable(res_data_q)));

endmodule

// File: tb/tb_gate_arbiter.sv
// Randomized and directed bench for gate_arbiter: grants are predicted from a
// rotating-priority model, results are queued at grant and compared on handshake.
module tb_gate_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int IDW  = 2;

   typedef enum int {M_IDLE, M_RANDOM, M_ALL} mode_e;
   typedef enum int {R_HIGH, R_LOW, R_RANDOM} rdy_e;
   typedef struct {
      int           id;
      logic [W-1:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   gate_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

   gate_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_err = 0;
   exp_t         sb[$];
   int           gnt_log[$];
   logic [W-1:0] res_log[$];

   bit           pending[NREQ];
   logic [1:0]   op_v[NREQ];
   logic [W-1:0] a_v[NREQ];
   logic [W-1:0] b_v[NREQ];
   mode_e        mode     = M_IDLE;
   rdy_e         rdy_mode = R_HIGH;

   int rr_ptr   = 0;
   bit idle_m   = 1'b1;
   bit acc_prev = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(logic [NREQ-1:0] r, int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [W-1:0] gate_ref(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
      case (o)
         2'd0:    return x & y;
         2'd1:    return x | y;
         2'd2:    return x ^ y;
         default: return ~(x & y);
      endcase
   endfunction

   function automatic bit pend_any();
      for (int i = 0; i < NREQ; i++)
         if (pending[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive();
      logic [NREQ-1:0]   r;
      logic [2*NREQ-1:0] o;
      logic [W*NREQ-1:0] av, bv;
      for (int i = 0; i < NREQ; i++) begin
         r[i]          = pending[i];
         o[2*i +: 2]   = op_v[i];
         av[W*i +: W]  = a_v[i];
         bv[W*i +: W]  = b_v[i];
      end
      bus.req = r;
      bus.op  = o;
      bus.a   = av;
      bus.b   = bv;
      case (rdy_mode)
         R_HIGH:  bus.res_ready = 1'b1;
         R_LOW:   bus.res_ready = 1'b0;
         default: bus.res_ready = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREQ; i++) pending[i] = 1'b0;
      sb.delete();
      idle_m   = 1'b1;
      acc_prev = 1'b0;
      rr_ptr   = 0;
   endtask

   task automatic set_req(int i, logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
      op_v[i]    = o;
      a_v[i]     = x;
      b_v[i]     = y;
      pending[i] = 1'b1;
   endtask

   // One clock: check grant/busy against the model, update requesters, drive inputs.
   task automatic step();
      logic [NREQ-1:0] req_seen, exp_gnt;
      int w;
      @(negedge clk);
      req_seen = bus.req;
      exp_gnt  = '0;
      w        = -1;
      if (idle_m && req_seen != '0) begin
         w       = rr_pick(req_seen, rr_ptr);
         exp_gnt = NREQ'(1) << w;
      end
      check("gnt", bus.gnt, exp_gnt);
      if (w >= 0) begin
         idle_m = 1'b0;
         rr_ptr = (w + 1) % NREQ;
         gnt_log.push_back(w);
         sb.push_back('{w, gate_ref(op_v[w], a_v[w], b_v[w])});
         case (mode)
            M_IDLE: begin
               pending[w] = 1'b0;
               a_v[w]     = '0;
            end
            M_RANDOM: begin
               pending[w] = 1'b0;
               op_v[w]    = 2'($urandom);
               a_v[w]     = W'($urandom);
               b_v[w]     = W'($urandom);
            end
            default: ;
         endcase
      end else if (acc_prev) begin
         idle_m = 1'b1;
      end
      check("busy", bus.busy, !idle_m);
      if (mode == M_RANDOM) begin
         for (int i = 0; i < NREQ; i++) begin
            if (i == w) continue;
            if (!pending[i] && $urandom_range(0, 2) == 0)
               set_req(i, 2'($urandom), W'($urandom), W'($urandom));
            else if (pending[i] && $urandom_range(0, 31) == 0)
               pending[i] = 1'b0;
         end
      end
      #1 drive();
      acc_prev = bus.res_valid && bus.res_ready;
   endtask

   task automatic wait_grants(int n, int max_cyc);
      int start = gnt_log.size();
      int c = 0;
      while (gnt_log.size() < start + n && c < max_cyc) begin
         step();
         c++;
      end
      check("grant_timeout", gnt_log.size() - start, n);
   endtask

   task automatic drain();
      int c = 0;
      mode     = M_IDLE;
      rdy_mode = R_HIGH;
      while ((pend_any() || sb.size() != 0 || !idle_m || bus.res_valid) && c < 300) begin
         step();
         c++;
      end
      check("drain_timeout", sb.size(), 0);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      model_reset();
      mode     = M_IDLE;
      rdy_mode = R_HIGH;
      drive();
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic reset_mid_exec(int first, logic [NREQ-1:0] after_req, int exp_id);
      set_req(first, 2'd2, W'($urandom), W'($urandom));
      drive();
      wait_grants(1, 10);
      rst_n = 1'b0;
      #1;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_gnt", bus.gnt, '0);
      check("rst_valid", bus.res_valid, 1'b0);
      model_reset();
      for (int i = 0; i < NREQ; i++)
         if (after_req[i]) set_req(i, 2'(i), W'($urandom), W'($urandom));
      drive();
      @(negedge clk);
      check("rst_valid_held", bus.res_valid, 1'b0);
      #1 rst_n = 1'b1;
      wait_grants(1, 10);
      check("rst_first_gnt", gnt_log[gnt_log.size()-1], exp_id);
      drain();
   endtask

   // Scoreboard monitor: samples after the inputs for the coming edge are settled.
   initial begin
      bit           pv = 1'b0, pr = 1'b0;
      logic [IDW-1:0] pid = '0;
      logic [W-1:0] pdat = '0;
      exp_t         e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            pv = 1'b0;
            continue;
         end
         if (pv && !pr) begin
            check("hold_valid", bus.res_valid, 1'b1);
            check("hold_id", bus.res_id, pid);
            check("hold_data", bus.res_data, pdat);
         end
         if (bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_result", bus.res_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               check("res_id", bus.res_id, e.id);
               check("res_data", bus.res_data, e.data);
               res_log.push_back(bus.res_data);
            end
         end
         pv   = bus.res_valid;
         pr   = bus.res_ready;
         pid  = bus.res_id;
         pdat = bus.res_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1);
   end

   initial begin
      int base, gbase;
      for (int i = 0; i < NREQ; i++) begin
         op_v[i]    = '0;
         a_v[i]     = '0;
         b_v[i]     = '0;
         pending[i] = 1'b0;
      end
      do_reset();
      check("reset_gnt", bus.gnt, '0);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_valid", bus.res_valid, 1'b0);
      check("reset_id", bus.res_id, '0);
      check("reset_data", bus.res_data, '0);

      // Single AND request; a0 is zeroed right after the grant.
      set_req(0, 2'd0, 8'hF0, 8'h3C);
      drive();
      wait_grants(1, 10);
      check("t1_gnt_id", gnt_log[gnt_log.size()-1], 0);
      drain();
      check("t1_data", res_log[res_log.size()-1], 8'h30);

      // Wrap-around: after id1, pointer sits at 2 and 0011 must pick id0.
      set_req(1, 2'd1, W'($urandom), W'($urandom));
      drive();
      wait_grants(1, 10);
      check("t2_first", gnt_log[gnt_log.size()-1], 1);
      drain();
      set_req(0, 2'd3, W'($urandom), W'($urandom));
      set_req(1, 2'd2, W'($urandom), W'($urandom));
      drive();
      wait_grants(1, 10);
      check("t2_wrap", gnt_log[gnt_log.size()-1], 0);
      wait_grants(1, 10);
      check("t2_after_wrap", gnt_log[gnt_log.size()-1], 1);
      drain();

      // Back-pressure: result held while a new request waits.
      rdy_mode = R_LOW;
      set_req(2, 2'd1, W'($urandom), W'($urandom));
      drive();
      wait_grants(1, 10);
      begin
         int c = 0;
         while (!bus.res_valid && c < 10) begin
            step();
            c++;
         end
      end
      check("t3_valid_rise", bus.res_valid, 1'b1);
      gbase = gnt_log.size();
      set_req(3, 2'd2, W'($urandom), W'($urandom));
      repeat (5) step();
      check("t3_valid_held", bus.res_valid, 1'b1);
      check("t3_no_gnt", gnt_log.size(), gbase);
      rdy_mode = R_HIGH;
      step();
      check("t3_accept_cycle", bus.res_valid, 1'b1);
      step();
      check("t3_valid_drop", bus.res_valid, 1'b0);
      check("t3_idle_gnt", bus.gnt, '0);
      step();
      check("t3_next_gnt", bus.gnt, 4'b1000);
      drain();

      // Reset during EXEC, then arbitration restarts from pointer 0.
      reset_mid_exec(2, 4'b1000, 3);
      reset_mid_exec(2, 4'b1010, 1);

      // All requesters held: grants rotate and each opcode shows up once.
      do_reset();
      mode = M_ALL;
      for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 8'hAA, 8'h0F);
      drive();
      gbase = gnt_log.size();
      base  = res_log.size();
      wait_grants(5, 40);
      for (int k = 0; k < 5; k++)
         check("t5_rotation", gnt_log[gbase + k], k % NREQ);
      drain();
      check("t5_and", res_log[base + 0], 8'h0A);
      check("t5_or", res_log[base + 1], 8'hAF);
      check("t5_xor", res_log[base + 2], 8'hA5);
      check("t5_nand", res_log[base + 3], 8'hF5);

      // Random traffic with random back-pressure.
      mode     = M_RANDOM;
      rdy_mode = R_RANDOM;
      repeat (2000) step();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
